// File: rtl/bcd2bin_convertidor_pkg.sv
// Purpose: shared constants for the BCD-to-binary converter (sizes, FSM codes, digit correction).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

  // Default geometry: 4 packed BCD digits -> 14-bit binary (9999 < 2^14).
  localparam int DIGITOS_DEF   = 4;
  localparam int ANCHO_BIN_DEF = 14;

  // FSM encoding, kept as plain constants so older tools read it the same way.
  localparam logic [0:0] REPOSO    = 1'b0;
  localparam logic [0:0] DESPLAZAR = 1'b1;

  // Reverse double-dabble correction: after a right shift a digit that reads
  // >= 8 received a bit worth 5 from the digit above, not 8, so take 3 off.
  localparam logic [3:0] UMBRAL_BCD = 4'd8;
  localparam logic [3:0] RESTA_BCD  = 4'd3;

  // Largest legal BCD digit; anything above rejects the start request.
  localparam logic [3:0] DIGITO_MAX = 4'd9;

endpackage

// File: rtl/bcd2bin_convertidor_contador_iteraciones.sv
// Purpose: loadable down-counter that meters the shift iterations of one conversion.
// Latency: load/decrement take effect on the next rising edge; fin_contador is combinational.
// Backpressure: none; carga has priority over decrementar.
// Ports: reloj (clock), reset (sync, active-high), carga (load VALOR_CARGA),
//        decrementar (count down, saturates at 0), fin_contador (count == 1, i.e. last step now).
module contador_iteraciones #(
  parameter int ANCHO       = 5,
  parameter int VALOR_CARGA = 16
) (
  input  logic reloj,
  input  logic reset,
  input  logic carga,
  input  logic decrementar,
  output logic fin_contador
);

  localparam logic [ANCHO-1:0] CARGA_INI = ANCHO'(VALOR_CARGA);
  localparam logic [ANCHO-1:0] UNO       = ANCHO'(1);

  logic [ANCHO-1:0] cuenta_q;
  logic [ANCHO-1:0] cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (carga) begin
      cuenta_d = CARGA_INI;
    end else if (decrementar && (cuenta_q != '0)) begin
      cuenta_d = cuenta_q - UNO;
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  // The edge taken while the count reads 1 is the one that performs the final shift.
  assign fin_contador = (cuenta_q == UNO);

endmodule

// File: rtl/bcd2bin_convertidor.sv
// Purpose: sequential BCD-to-binary converter (reverse double-dabble), one conversion at a time.
// Latency: iniciar at edge N -> listo pulse in the cycle after edge N+4*DIGITOS; back-to-back adds 1 cycle.
// Backpressure: iniciar ignored while ocupado; start with a digit > 9 is rejected with an error_bcd pulse.
// Ports: reloj, reset (sync, active-high), iniciar, bcd_entrada[4*DIGITOS] (digit 0 in [3:0]),
//        bin_salida[ANCHO_BIN] (last good result), listo (result pulse), ocupado, error_bcd (reject pulse).
module bcd2bin_convertidor
  import calc_pkg::*;
#(
  parameter int DIGITOS   = DIGITOS_DEF,
  parameter int ANCHO_BIN = ANCHO_BIN_DEF
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [4*DIGITOS-1:0]   bcd_entrada,
  output logic [ANCHO_BIN-1:0]   bin_salida,
  output logic                   listo,
  output logic                   ocupado,
  output logic                   error_bcd
);

  localparam int ANCHO_BCD = 4 * DIGITOS;
  localparam int ANCHO_CNT = $clog2(ANCHO_BCD + 1);

  logic [0:0]           estado_q,     estado_d;
  logic [ANCHO_BCD-1:0] bcd_q,        bcd_d;
  // The binary half is as wide as the BCD half: every bit shifted out of the
  // BCD side must survive all 4*DIGITOS shifts, whatever ANCHO_BIN is.
  logic [ANCHO_BCD-1:0] bin_q,        bin_d;
  logic [ANCHO_BIN-1:0] bin_salida_q, bin_salida_d;
  logic                 listo_q,      listo_d;
  logic                 error_q,      error_d;

  logic                 carga;
  logic                 decrementar;
  logic                 fin_contador;

  logic [ANCHO_BCD-1:0] bcd_desp;
  logic [ANCHO_BCD-1:0] bcd_corr;
  logic [ANCHO_BCD-1:0] bin_desp;
  logic [DIGITOS-1:0]   digito_invalido;
  logic                 entrada_valida;
  logic [ANCHO_BIN-1:0] resultado;

  // Right shift of {bcd, bin}: bcd LSB moves into bin MSB, 0 enters bcd MSB.
  assign bcd_desp = {1'b0, bcd_q[ANCHO_BCD-1:1]};
  assign bin_desp = {bcd_q[0], bin_q[ANCHO_BCD-1:1]};

  // bin_q[0] falls off the end on every shift.
  logic lsb_unused;
  assign lsb_unused = bin_q[0];

  // Per-digit correction on the shifted value and per-digit input validation,
  // all digits in parallel.
  for (genvar g = 0; g < DIGITOS; g++) begin : g_digito
    assign bcd_corr[4*g +: 4] = (bcd_desp[4*g +: 4] >= UMBRAL_BCD)
                              ? (bcd_desp[4*g +: 4] - RESTA_BCD)
                              : bcd_desp[4*g +: 4];
    assign digito_invalido[g] = (bcd_entrada[4*g +: 4] > DIGITO_MAX);
  end

  assign entrada_valida = ~|digito_invalido;

  // Final value: zero-extend to ANCHO_BIN, or truncate if the port is narrower.
  if (ANCHO_BIN > ANCHO_BCD) begin : g_extender
    assign resultado = {{(ANCHO_BIN - ANCHO_BCD){1'b0}}, bin_desp};
  end else if (ANCHO_BIN == ANCHO_BCD) begin : g_igual
    assign resultado = bin_desp;
  end else begin : g_truncar
    logic [ANCHO_BCD-ANCHO_BIN-1:0] alto_unused;
    assign resultado   = bin_desp[ANCHO_BIN-1:0];
    assign alto_unused = bin_desp[ANCHO_BCD-1:ANCHO_BIN];
  end

  always_comb begin
    estado_d     = estado_q;
    bcd_d        = bcd_q;
    bin_d        = bin_q;
    bin_salida_d = bin_salida_q;
    listo_d      = 1'b0;
    error_d      = 1'b0;
    carga        = 1'b0;
    decrementar  = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (iniciar) begin
          if (entrada_valida) begin
            bcd_d    = bcd_entrada;
            bin_d    = '0;
            carga    = 1'b1;
            estado_d = DESPLAZAR;
          end else begin
            error_d  = 1'b1;
          end
        end
      end
      DESPLAZAR: begin
        bcd_d       = bcd_corr;
        bin_d       = bin_desp;
        decrementar = 1'b1;
        if (fin_contador) begin
          bin_salida_d = resultado;
          listo_d      = 1'b1;
          estado_d     = REPOSO;
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q     <= REPOSO;
      bcd_q        <= '0;
      bin_q        <= '0;
      bin_salida_q <= '0;
      listo_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      bcd_q        <= bcd_d;
      bin_q        <= bin_d;
      bin_salida_q <= bin_salida_d;
      listo_q      <= listo_d;
      error_q      <= error_d;
    end
  end

  contador_iteraciones #(
    .ANCHO       (ANCHO_CNT),
    .VALOR_CARGA (ANCHO_BCD)
  ) u_contador (
    .reloj        (reloj),
    .reset        (reset),
    .carga        (carga),
    .decrementar  (decrementar),
    .fin_contador (fin_contador)
  );

  assign bin_salida = bin_salida_q;
  assign listo      = listo_q;
  assign ocupado    = (estado_q == DESPLAZAR);
  assign error_bcd  = error_q;

endmodule
